// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : atm_pkg
//  Description : Shared types and default widths for the ATM transaction
//                controller: FSM state encoding and transaction opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

    localparam int DEF_BAL_W = 8;   // default balance width
    localparam int DEF_AMT_W = 6;   // default switch amount/PIN width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PIN   = 3'd1,
        ST_READY = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_LOCK  = 3'd5
    } state_t;

    typedef enum logic {
        OP_DEP = 1'b0,
        OP_WDR = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/atm_txn_controller_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hold_timer
//  Description : Loadable down-counter that times how long a result is shown.
//                start loads HOLD_CYCLES; done is high during the last cycle
//                of the hold window (counter == 1).
//  Ports       : clk, reset (async, active-high), start (load), done
//  Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int          CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= C_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    // Loaded on the edge that enters HOLD, so the window is exactly
    // HOLD_CYCLES cycles when the FSM leaves on the cycle where count == 1.
    assign done = (r_cnt == C_ONE);

endmodule
`default_nettype wire

// File: rtl/atm_txn_controller.sv
`default_nettype none
// ============================================================================
//  Module      : atm_txn_controller
//  Description : ATM transaction sequencer. Gates deposit/withdraw behind a
//                card-present and PIN check, owns the balance register,
//                enforces overflow / insufficient-funds / retry-lockout rules
//                and holds each result on the LEDs for HOLD_CYCLES cycles.
//  Ports       : clk, reset (async, active-high)
//                card_in, dep_req, wdr_req, sw[AMT_W]   - user inputs
//                balance[BAL_W]                         - to BCD display
//                led_ok, led_err, led_lock, ready       - status
//  Revision    : 1.0 - initial release
// ============================================================================
module atm_txn_controller
    import atm_pkg::*;
#(
    parameter int               BAL_W       = DEF_BAL_W,
    parameter int               AMT_W       = DEF_AMT_W,
    parameter logic [AMT_W-1:0] PIN         = 6'b101101,
    parameter int               MAX_TRIES   = 3,
    parameter int               HOLD_CYCLES = 50_000_000,
    parameter logic [BAL_W-1:0] INIT_BAL    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_in,
    input  logic             dep_req,
    input  logic             wdr_req,
    input  logic [AMT_W-1:0] sw,
    output logic [BAL_W-1:0] balance,
    output logic             led_ok,
    output logic             led_err,
    output logic             led_lock,
    output logic             ready
);

    localparam int              TRY_W = $clog2(MAX_TRIES + 1);
    localparam int              PAD_W = BAL_W + 1 - AMT_W;
    localparam logic [TRY_W-1:0] C_MAX_TRIES = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] C_TRY_ONE   = TRY_W'(1);

    state_t           r_state, w_state_nxt;
    state_t           r_ret,   w_ret_nxt;
    op_t              r_op,    w_op_nxt;
    logic [AMT_W-1:0] r_amt,   w_amt_nxt;
    logic [BAL_W-1:0] r_bal,   w_bal_nxt;
    logic [TRY_W-1:0] r_tries, w_tries_nxt;
    logic             r_led_ok,  w_led_ok_nxt;
    logic             r_led_err, w_led_err_nxt;
    logic             w_start;
    logic             w_done;

    // Arithmetic carried one bit wider so the top bit flags carry/borrow.
    logic [BAL_W:0]   w_amt_ext;
    logic [BAL_W:0]   w_sum;
    logic [BAL_W:0]   w_diff;
    logic [TRY_W-1:0] w_tries_inc;

    assign w_amt_ext   = {{PAD_W{1'b0}}, r_amt};
    assign w_sum       = {1'b0, r_bal} + w_amt_ext;
    assign w_diff      = {1'b0, r_bal} - w_amt_ext;
    assign w_tries_inc = r_tries + C_TRY_ONE;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .done  (w_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ret     <= ST_IDLE;
            r_op      <= OP_DEP;
            r_amt     <= '0;
            r_bal     <= INIT_BAL;
            r_tries   <= '0;
            r_led_ok  <= 1'b0;
            r_led_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_op      <= w_op_nxt;
            r_amt     <= w_amt_nxt;
            r_bal     <= w_bal_nxt;
            r_tries   <= w_tries_nxt;
            r_led_ok  <= w_led_ok_nxt;
            r_led_err <= w_led_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret;
        w_op_nxt      = r_op;
        w_amt_nxt     = r_amt;
        w_bal_nxt     = r_bal;
        w_tries_nxt   = r_tries;
        w_led_ok_nxt  = r_led_ok;
        w_led_err_nxt = r_led_err;
        w_start       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (card_in) w_state_nxt = ST_PIN;
            end

            ST_PIN: begin
                if (!card_in) begin
                    w_state_nxt = ST_IDLE;
                    w_tries_nxt = '0;
                end else if (dep_req || wdr_req) begin
                    if (sw == PIN) begin
                        w_state_nxt = ST_READY;
                        w_tries_nxt = '0;
                    end else begin
                        w_tries_nxt = w_tries_inc;
                        if (w_tries_inc == C_MAX_TRIES) begin
                            w_state_nxt = ST_LOCK;
                        end else begin
                            w_state_nxt   = ST_HOLD;
                            w_ret_nxt     = ST_PIN;
                            w_led_err_nxt = 1'b1;
                            w_start       = 1'b1;
                        end
                    end
                end
            end

            ST_READY: begin
                if (!card_in) begin
                    w_state_nxt = ST_IDLE;
                    w_tries_nxt = '0;
                end else if (dep_req && wdr_req) begin
                    w_state_nxt   = ST_HOLD;
                    w_ret_nxt     = ST_READY;
                    w_led_err_nxt = 1'b1;
                    w_start       = 1'b1;
                end else if (dep_req || wdr_req) begin
                    w_state_nxt = ST_EXEC;
                    w_op_nxt    = dep_req ? OP_DEP : OP_WDR;
                    w_amt_nxt   = sw;
                end
            end

            ST_EXEC: begin
                // Commit always happens; card removal only redirects the
                // next state and suppresses the result LEDs.
                if (r_op == OP_DEP) begin
                    if (!w_sum[BAL_W]) w_bal_nxt = w_sum[BAL_W-1:0];
                end else begin
                    if (!w_diff[BAL_W]) w_bal_nxt = w_diff[BAL_W-1:0];
                end
                if (card_in) begin
                    w_state_nxt   = ST_HOLD;
                    w_ret_nxt     = ST_READY;
                    w_start       = 1'b1;
                    w_led_ok_nxt  = (r_op == OP_DEP) ? !w_sum[BAL_W] : !w_diff[BAL_W];
                    w_led_err_nxt = (r_op == OP_DEP) ?  w_sum[BAL_W] :  w_diff[BAL_W];
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_tries_nxt = '0;
                end
            end

            ST_HOLD: begin
                if (!card_in) begin
                    w_state_nxt   = ST_IDLE;
                    w_tries_nxt   = '0;
                    w_led_ok_nxt  = 1'b0;
                    w_led_err_nxt = 1'b0;
                end else if (w_done) begin
                    w_state_nxt   = r_ret;
                    w_led_ok_nxt  = 1'b0;
                    w_led_err_nxt = 1'b0;
                end
            end

            ST_LOCK: begin
                // Terminal until reset.
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_led_ok_nxt  = 1'b0;
                w_led_err_nxt = 1'b0;
            end
        endcase
    end

    assign balance  = r_bal;
    assign led_ok   = r_led_ok;
    assign led_err  = r_led_err;
    assign led_lock = (r_state == ST_LOCK);
    assign ready    = (r_state == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_atm_txn_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_atm_txn_controller
//  Description : Directed self-checking bench for atm_txn_controller with
//                HOLD_CYCLES=4, INIT_BAL=0, PIN=45.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_txn_controller;

    logic       clk;
    logic       reset;
    logic       card_in;
    logic       dep_req;
    logic       wdr_req;
    logic [5:0] sw;
    logic [7:0] balance;
    logic       led_ok;
    logic       led_err;
    logic       led_lock;
    logic       ready;

    int checks = 0;
    int errors = 0;

    atm_txn_controller #(
        .BAL_W       (8),
        .AMT_W       (6),
        .PIN         (6'd45),
        .MAX_TRIES   (3),
        .HOLD_CYCLES (4),
        .INIT_BAL    (8'd0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .card_in  (card_in),
        .dep_req  (dep_req),
        .wdr_req  (wdr_req),
        .sw       (sw),
        .balance  (balance),
        .led_ok   (led_ok),
        .led_err  (led_err),
        .led_lock (led_lock),
        .ready    (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock edge; sampling point is 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a request for one sampling edge.
    task automatic pulse(input logic d, input logic w, input logic [5:0] v);
        sw      = v;
        dep_req = d;
        wdr_req = w;
        tick();
        dep_req = 1'b0;
        wdr_req = 1'b0;
    endtask

    task automatic do_reset();
        card_in = 1'b0;
        dep_req = 1'b0;
        wdr_req = 1'b0;
        sw      = '0;
        reset   = 1'b1;
        ticks(2);
        reset   = 1'b0;
    endtask

    // Card in, then correct PIN; ends in READY.
    task automatic login();
        card_in = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 6'd45);
    endtask

    // Request then commit edge; ends just after the commit (in HOLD).
    task automatic txn(input logic d, input logic w, input logic [5:0] v);
        pulse(d, w, v);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #2;
        checks++; if (balance !== 8'd0) begin errors++; $display("FAIL reset_balance: got %0d expected 0", balance); end
        checks++; if ({led_ok, led_err, led_lock, ready} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b expected 0000", {led_ok, led_err, led_lock, ready}); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready: got %b expected 0", ready); end
    endtask

    task automatic test_pin_entry();
        do_reset();
        card_in = 1'b1;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pin_state_ready: got %b expected 0", ready); end
        pulse(1'b1, 1'b0, 6'd45);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL pin_ok_ready: got %b expected 1", ready); end
        card_in = 1'b0;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pin_card_out: got %b expected 0", ready); end
        card_in = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 6'd44);
        for (int i = 0; i < 4; i++) begin
            checks++; if (led_err !== 1'b1) begin errors++; $display("FAIL pin_bad_err cycle %0d: got %b expected 1", i, led_err); end
            tick();
        end
        checks++; if (led_err !== 1'b0) begin errors++; $display("FAIL pin_err_clear: got %b expected 0", led_err); end
        pulse(1'b0, 1'b1, 6'd45);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL pin_retry_ready: got %b expected 1", ready); end
        checks++; if (led_lock !== 1'b0) begin errors++; $display("FAIL pin_no_lock: got %b expected 0", led_lock); end
    endtask

    task automatic test_lockout();
        do_reset();
        login();
        txn(1'b1, 1'b0, 6'd20);
        ticks(4);
        card_in = 1'b0;
        tick();
        card_in = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 6'd1);
        ticks(4);
        pulse(1'b0, 1'b1, 6'd2);
        ticks(4);
        checks++; if (led_lock !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", led_lock); end
        pulse(1'b1, 1'b0, 6'd3);
        checks++; if (led_lock !== 1'b1) begin errors++; $display("FAIL lock_set: got %b expected 1", led_lock); end
        card_in = 1'b0;
        ticks(2);
        card_in = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 6'd45);
        pulse(1'b1, 1'b0, 6'd5);
        tick();
        checks++; if ({led_lock, ready} !== 2'b10) begin errors++; $display("FAIL lock_hold: got %b expected 10", {led_lock, ready}); end
        checks++; if (balance !== 8'd20) begin errors++; $display("FAIL lock_balance: got %0d expected 20", balance); end
        reset = 1'b1;
        #2;
        checks++; if (led_lock !== 1'b0) begin errors++; $display("FAIL lock_reset: got %b expected 0", led_lock); end
        checks++; if (balance !== 8'd0) begin errors++; $display("FAIL lock_reset_bal: got %0d expected 0", balance); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_deposit_overflow();
        int exp_bal;
        do_reset();
        login();
        exp_bal = 0;
        for (int k = 0; k < 4; k++) begin
            pulse(1'b1, 1'b0, 6'd63);
            checks++; if (balance !== 8'(exp_bal)) begin errors++; $display("FAIL dep_exec_bal %0d: got %0d expected %0d", k, balance, exp_bal); end
            tick();
            exp_bal += 63;
            checks++; if (balance !== 8'(exp_bal)) begin errors++; $display("FAIL dep_bal %0d: got %0d expected %0d", k, balance, exp_bal); end
            checks++; if ({led_ok, led_err} !== 2'b10) begin errors++; $display("FAIL dep_led %0d: got %b expected 10", k, {led_ok, led_err}); end
            ticks(4);
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL dep_ready %0d: got %b expected 1", k, ready); end
        end
        txn(1'b1, 1'b0, 6'd4);
        checks++; if (balance !== 8'd252) begin errors++; $display("FAIL dep_ovf_bal: got %0d expected 252", balance); end
        checks++; if ({led_ok, led_err} !== 2'b01) begin errors++; $display("FAIL dep_ovf_led: got %b expected 01", {led_ok, led_err}); end
        ticks(4);
        txn(1'b1, 1'b0, 6'd3);
        checks++; if (balance !== 8'd255) begin errors++; $display("FAIL dep_max_bal: got %0d expected 255", balance); end
        checks++; if ({led_ok, led_err} !== 2'b10) begin errors++; $display("FAIL dep_max_led: got %b expected 10", {led_ok, led_err}); end
        ticks(4);
    endtask

    task automatic test_withdraw();
        do_reset();
        login();
        txn(1'b1, 1'b0, 6'd10);
        ticks(4);
        txn(1'b0, 1'b1, 6'd11);
        checks++; if (balance !== 8'd10) begin errors++; $display("FAIL wdr_nsf_bal: got %0d expected 10", balance); end
        checks++; if ({led_ok, led_err} !== 2'b01) begin errors++; $display("FAIL wdr_nsf_led: got %b expected 01", {led_ok, led_err}); end
        ticks(4);
        txn(1'b0, 1'b1, 6'd10);
        checks++; if (balance !== 8'd0) begin errors++; $display("FAIL wdr_all_bal: got %0d expected 0", balance); end
        checks++; if ({led_ok, led_err} !== 2'b10) begin errors++; $display("FAIL wdr_all_led: got %b expected 10", {led_ok, led_err}); end
        ticks(4);
        txn(1'b0, 1'b1, 6'd0);
        checks++; if (balance !== 8'd0) begin errors++; $display("FAIL wdr_zero_bal: got %0d expected 0", balance); end
        checks++; if ({led_ok, led_err} !== 2'b10) begin errors++; $display("FAIL wdr_zero_led: got %b expected 10", {led_ok, led_err}); end
        ticks(4);
    endtask

    task automatic test_conflicts();
        do_reset();
        login();
        txn(1'b1, 1'b0, 6'd7);
        ticks(4);
        pulse(1'b1, 1'b1, 6'd5);
        checks++; if ({led_ok, led_err} !== 2'b01) begin errors++; $display("FAIL conflict_led: got %b expected 01", {led_ok, led_err}); end
        checks++; if (balance !== 8'd7) begin errors++; $display("FAIL conflict_bal: got %0d expected 7", balance); end
        pulse(1'b1, 1'b0, 6'd9);
        checks++; if (led_err !== 1'b1) begin errors++; $display("FAIL hold_ignore_err: got %b expected 1", led_err); end
        ticks(3);
        checks++; if ({ready, led_err} !== 2'b10) begin errors++; $display("FAIL hold_return: got %b expected 10", {ready, led_err}); end
        ticks(2);
        checks++; if (balance !== 8'd7) begin errors++; $display("FAIL hold_ignore_bal: got %0d expected 7", balance); end
    endtask

    task automatic test_card_removal();
        do_reset();
        login();
        pulse(1'b1, 1'b0, 6'd5);
        card_in = 1'b0;
        tick();
        checks++; if (balance !== 8'd5) begin errors++; $display("FAIL exec_remove_bal: got %0d expected 5", balance); end
        checks++; if ({led_ok, led_err, ready} !== 3'b000) begin errors++; $display("FAIL exec_remove_out: got %b expected 000", {led_ok, led_err, ready}); end
        tick();
        card_in = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 6'd45);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL relogin_ready: got %b expected 1", ready); end
        txn(1'b1, 1'b0, 6'd2);
        card_in = 1'b0;
        tick();
        checks++; if ({led_ok, ready} !== 2'b00) begin errors++; $display("FAIL hold_remove: got %b expected 00", {led_ok, ready}); end
        checks++; if (balance !== 8'd7) begin errors++; $display("FAIL hold_remove_bal: got %0d expected 7", balance); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        login();
        txn(1'b1, 1'b0, 6'd20);
        tick();
        checks++; if ({led_ok, balance} !== {1'b1, 8'd20}) begin errors++; $display("FAIL pre_reset: got %b/%0d expected 1/20", led_ok, balance); end
        reset = 1'b1;
        #2;
        checks++; if (balance !== 8'd0) begin errors++; $display("FAIL async_reset_bal: got %0d expected 0", balance); end
        checks++; if ({led_ok, led_err, led_lock, ready} !== 4'b0000) begin errors++; $display("FAIL async_reset_out: got %b expected 0000", {led_ok, led_err, led_lock, ready}); end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        card_in = 1'b0;
        dep_req = 1'b0;
        wdr_req = 1'b0;
        sw      = '0;
        test_reset();
        test_pin_entry();
        test_lockout();
        test_deposit_overflow();
        test_withdraw();
        test_conflicts();
        test_card_removal();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
